// File: rtl/gc_pkg.sv
// Shared FSM encoding and default timing constants for the button conditioner.
package gc_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    REPEAT  = 2'd2
  } btn_fsm_e;

  // Defaults assume a 50 MHz clock.
  localparam int DEB_CYCLES  = 500000;
  localparam int HOLD_CYCLES = 25000000;
  localparam int RPT_START   = 12500000;
  localparam int RPT_MIN     = 1562500;
endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer followed by a stable-count debouncer.
module sync_debounce #(
  parameter int DEB_CYCLES = gc_pkg::DEB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic noisy,
  output logic clean
);
  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic          meta, sync;
  logic [CW-1:0] cnt;

  // Counter tracks how long sync has disagreed with clean; any agreement restarts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      clean <= 1'b0;
      cnt   <= '0;
    end else begin
      meta <= noisy;
      sync <= meta;
      if (sync == clean) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        clean <= ~clean;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/button_conditioner.sv
// Debounced push-button with press/release strobes, long-press hold and accelerating auto-repeat.
module button_conditioner #(
  parameter int DEB_CYCLES  = gc_pkg::DEB_CYCLES,
  parameter int HOLD_CYCLES = gc_pkg::HOLD_CYCLES,
  parameter int RPT_START   = gc_pkg::RPT_START,
  parameter int RPT_MIN     = gc_pkg::RPT_MIN
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic button_state,
  output logic press_pulse,
  output logic release_pulse,
  output logic hold,
  output logic step_pulse
);
  import gc_pkg::*;

  localparam int HW = $clog2(HOLD_CYCLES);
  localparam int RW = $clog2(RPT_START + 1);

  btn_fsm_e      fsm;
  logic          state_d;
  logic [HW-1:0] hold_cnt;
  logic [RW-1:0] period, rpt_cnt, half, next_period;
  logic          hold_hit, rpt_hit;

  sync_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .clk   (clk),
    .rst   (rst),
    .noisy (button),
    .clean (button_state)
  );

  assign press_pulse   = button_state & ~state_d;
  assign release_pulse = ~button_state & state_d;

  assign hold_hit    = (fsm == PRESSED) && (hold_cnt == HW'(HOLD_CYCLES - 1));
  assign rpt_hit     = (fsm == REPEAT) && (rpt_cnt == period - 1'b1);
  assign half        = period >> 1;
  assign next_period = (half < RW'(RPT_MIN)) ? RW'(RPT_MIN) : half;

  // Strobes and hold decode flops only; release suppresses any coincident event.
  assign step_pulse = ~release_pulse &
                      (((fsm == IDLE) & press_pulse) | hold_hit | rpt_hit);
  assign hold       = ~release_pulse & ((fsm == REPEAT) | hold_hit);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm      <= IDLE;
      state_d  <= 1'b0;
      hold_cnt <= '0;
      rpt_cnt  <= '0;
      period   <= RW'(RPT_START);
    end else begin
      state_d <= button_state;
      case (fsm)
        IDLE: begin
          if (press_pulse) begin
            fsm      <= PRESSED;
            hold_cnt <= '0;
          end
        end
        PRESSED: begin
          if (release_pulse) begin
            fsm <= IDLE;
          end else if (hold_hit) begin
            fsm     <= REPEAT;
            period  <= RW'(RPT_START);
            rpt_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        REPEAT: begin
          if (release_pulse) begin
            fsm <= IDLE;
          end else if (rpt_hit) begin
            rpt_cnt <= '0;
            period  <= next_period;
          end else begin
            rpt_cnt <= rpt_cnt + 1'b1;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_button_conditioner.sv
// Randomized bench for button_conditioner against a cycle-indexed behavioural model.
module tb_button_conditioner;
  localparam int DEB  = 4;
  localparam int HOLD = 20;
  localparam int RS   = 8;
  localparam int RM   = 2;
  localparam int MAXC = 4000;

  logic clk = 1'b0;
  logic rst, button;
  logic button_state, press_pulse, release_pulse, hold, step_pulse;

  always #5 clk = ~clk;

  button_conditioner #(
    .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .RPT_START(RS), .RPT_MIN(RM)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .button        (button),
    .button_state  (button_state),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .hold          (hold),
    .step_pulse    (step_pulse)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", tag, obs, exp);
    end
  endtask

  // Stimulus: b/r hold the button and rst values driven at the falling edge of cycle k.
  bit b[MAXC];
  bit r[MAXC];
  bit st[MAXC];
  int ncyc = 0;
  int s    = 0;
  int pcyc = 0;

  task automatic seg(input int len, input bit lvl, input bit rn);
    for (int i = 0; i < len; i++) begin
      b[ncyc] = lvl;
      r[ncyc] = rn;
      ncyc++;
    end
  endtask

  function automatic bit sync_at(input int j);
    return (j - 2 >= s) ? b[j-2] : 1'b0;
  endfunction

  // Steps occur at press, at hold entry, then after RS, RS/2, ... floored at RM.
  function automatic bit is_step(input int t);
    int p, a;
    if (t == 0) return 1'b1;
    if (t < HOLD) return 1'b0;
    p = RS;
    a = 0;
    while (a < t - HOLD) begin
      a += p;
      p = (p / 2 < RM) ? RM : p / 2;
    end
    return a == t - HOLD;
  endfunction

  initial begin
    bit in_rst, tog, e_pp, e_rp, e_st, e_hd;
    string cs;

    rst    = 1'b0;
    button = 1'b0;

    seg(3, 0, 0);                    // power-on reset
    seg(10, 0, 1);
    seg(30, 1, 1);  seg(20, 0, 1);   // clean press / release
    seg(3, 1, 1);   seg(20, 0, 1);   // short glitch, ignored
    seg(80, 1, 1);  seg(20, 0, 1);   // long hold with accelerating repeat
    seg(20, 1, 1);  seg(20, 0, 1);   // release lands on the hold-entry cycle
    seg(36, 1, 1);  seg(3, 1, 0);    // reset asserted during repeat
    seg(40, 1, 1);  seg(20, 0, 1);
    seg(1, 1, 1); seg(1, 0, 1); seg(1, 1, 1); seg(1, 0, 1);
    seg(30, 1, 1);  seg(20, 0, 1);   // bouncing press
    for (int i = 0; i < 40; i++) seg($urandom_range(1, 8), 1'($urandom_range(0, 1)), 1);
    for (int i = 0; i < 6; i++) begin
      seg($urandom_range(20, 70), 1, 1);
      seg($urandom_range(5, 15), 0, 1);
    end
    seg(30, 1, 1);  seg(2, 1, 0);  seg(30, 1, 1);  seg(15, 0, 1);

    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      in_rst = (k == 0) || !r[k-1];
      if (in_rst) begin
        st[k] = 1'b0;
      end else begin
        tog = 1'b1;
        for (int j = k - DEB; j < k; j++)
          if (j < s || sync_at(j) == st[k-1] || st[j] != st[k-1]) tog = 1'b0;
        st[k] = tog ? ~st[k-1] : st[k-1];
      end
      e_pp = !in_rst && st[k] && !st[k-1];
      e_rp = !in_rst && !st[k] && st[k-1];
      if (e_pp) pcyc = k;
      e_st = st[k] && is_step(k - pcyc);
      e_hd = st[k] && (k - pcyc >= HOLD);

      cs = $sformatf("@%0d", k);
      check({"button_state", cs},  button_state,  st[k]);
      check({"press_pulse", cs},   press_pulse,   e_pp);
      check({"release_pulse", cs}, release_pulse, e_rp);
      check({"step_pulse", cs},    step_pulse,    e_st);
      check({"hold", cs},          hold,          e_hd);

      button = b[k];
      rst    = r[k];
      if (r[k] && (k == 0 || !r[k-1])) s = k;
      if (!r[k] && k > 0 && r[k-1]) begin
        #1;
        check({"async_rst_state", cs}, button_state, 1'b0);
        check({"async_rst_step", cs},  step_pulse,   1'b0);
        check({"async_rst_hold", cs},  hold,         1'b0);
        check({"async_rst_press", cs}, press_pulse,  1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
